imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream feeder for the single-cycle MIPS core. Receives a program as a byte stream
//  (valid/ready), assembles big-endian 32-bit instructions and writes them into the
//  instruction memory write port. Holds the core in reset (cpu_rst_n=0) until the image
//  is fully written, then releases it. One load per reset.
// PARAMETERS
//  INST_WIDTH   32  instruction word width; fixed at 32 (4 bytes per word)
//  ADDR_WIDTH   8   instruction memory word-address width; DEPTH = 2**ADDR_WIDTH words
// PORTS
//  CLK         in   1           system clock, rising edge
//  RST         in   1           asynchronous reset, active-low
//  byte_valid  in   1           source presents byte_data
//  byte_data   in   8           stream byte
//  byte_ready  out  1           loader accepts a byte; transfer = byte_valid & byte_ready
//  imem_we     out  1           one-cycle write strobe to instruction memory
//  imem_addr   out  ADDR_WIDTH  word address of write
//  imem_wdata  out  INST_WIDTH  instruction word written
//  cpu_rst_n   out  1           active-low reset to the core; 0 while loading
//  done        out  1           sticky: image fully loaded
//  err         out  1           sticky: declared length > DEPTH
// BEHAVIOUR
//  Reset (RST=0, async): state=LEN_HI; byte_ready=0; imem_we=0; imem_addr=0; imem_wdata=0;
//   cpu_rst_n=0; done=0; err=0; byte/word counters=0. Reset mid-load aborts the load; no
//   further writes. Memory contents are not cleared.
//  byte_ready: registered; 1 in LEN_HI/LEN_LO/DATA from the first edge after RST rises;
//   0 in DONE and ERR. There is no backpressure inside DATA.
//  Frame: byte0,byte1 = word count N (16-bit, big-endian); then N*4 data bytes, each word
//   big-endian (first byte -> [31:24]).
//  FSM (advances only on an accepted byte, except where noted):
//   LEN_HI -> LEN_LO  : latch N[15:8]
//   LEN_LO -> DATA    : latch N[7:0]; if N==0 -> DONE; if N>DEPTH -> ERR
//   DATA   : 2-bit byte counter; on 4th byte, the word is complete
//            -> DATA, or -> DONE if the word index == N-1
//   DONE, ERR : terminal until reset; bytes ignored (byte_ready=0)
//  Write timing: the 4th byte is accepted at edge k. After edge k: imem_we=1,
//   imem_addr=word index, imem_wdata=assembled word. imem_we is 0 after edge k+1.
//   The word index increments by 1 per write, starting at 0. It never wraps, because
//   N<=DEPTH is guaranteed.
//  done=1 after the edge that writes the last word (after the LEN_LO edge if N==0).
//   cpu_rst_n is registered from done and rises one edge later, so the final write
//   completes before the core leaves reset.
//  err=1 on entering ERR; cpu_rst_n stays 0; imem_we is never asserted.
//  byte_valid low mid-word: the partial word is held indefinitely; no timeout.
//  Byte acceptance and an imem_we pulse may occur in the same cycle.
// STRUCTURE
//  Package imem_boot_pkg: state encoding (LEN_HI, LEN_LO, DATA, DONE, ERR),
//   BYTES_PER_WORD=4, LEN_BYTES=2.
//  Sub-module byte_packer: shift-in of 8-bit bytes into a 32-bit register, plus a 2-bit
//   counter. Outputs word_valid on the 4th byte and clears the counter on that byte.
//  Top level: FSM, length register, word index, write register, cpu_rst_n/done/err flops.
// TESTING
//  1 Reset release, N=2, bytes 00 02 | 20 08 00 05 | AC 08 00 3C
//    -> writes [0]=0x20080005, [1]=0xAC08003C; done=1; cpu_rst_n=1 one cycle after 2nd imem_we.
//  2 N=0 (bytes 00 00) -> no imem_we; done=1 after 2nd byte; cpu_rst_n=1 one cycle later;
//    byte_ready=0.
//  3 N=0x0101 with ADDR_WIDTH=8 -> err=1, byte_ready=0, cpu_rst_n stays 0, no writes.
//  4 Same image as 1 with byte_valid gaps of 0-5 cycles between bytes -> identical writes
//    and data.
//  5 RST asserted after 6 bytes of test 1, then released -> all outputs at reset values;
//    reload of test 1 succeeds, starting at addr 0.
//  6 N=DEPTH (256) of incrementing words -> last write addr=0xFF; no wrap;
//    done set exactly once.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared loader state encoding and frame constants.
package imem_boot_pkg;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES = 2;
endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// byte_packer: shifts stream bytes into a big-endian word, flags the 4th byte.
module byte_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt;
  logic [23:0] sr;
  assign word_valid = en && cnt == 2'(BYTES_PER_WORD - 1);
  // The current byte completes the word combinationally so it can be registered on the same edge.
  assign word = {sr, data};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sr  <= '0;
    end else if (en) begin
      cnt <= word_valid ? '0 : cnt + 2'd1;
      sr  <= {sr[15:0], data};
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed byte stream into instruction memory,
// holding the core in reset until the image is complete.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  done,
  output logic                  err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  state_t state, next;
  logic [7:0] len_hi;
  logic [15:0] len, n;
  logic [ADDR_WIDTH-1:0] idx;
  logic accept, word_valid, last;
  logic [31:0] word;
  assign accept = byte_valid & byte_ready;
  assign n = {len_hi, byte_data};
  assign last = 32'(idx) + 32'd1 == 32'(len);
  byte_packer u_packer (
    .clk(clk), .rst_n(rst_n), .en(accept && state == DATA), .data(byte_data),
    .word(word), .word_valid(word_valid)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LEN_HI;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      LEN_HI: next = accept ? LEN_LO : LEN_HI;
      LEN_LO: next = !accept ? LEN_LO : n == 16'd0 ? DONE : 32'(n) > DEPTH ? ERR : DATA;
      DATA:   next = word_valid && last ? DONE : DATA;
      default: next = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_hi     <= '0;
      len        <= '0;
      idx        <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst_n  <= 1'b0;
    end else begin
      if (accept && state == LEN_HI) len_hi <= byte_data;
      if (accept && state == LEN_LO) len <= n;
      byte_ready <= next inside {LEN_HI, LEN_LO, DATA};
      imem_we    <= word_valid;
      if (word_valid) begin
        imem_addr  <= idx;
        imem_wdata <= word;
        idx        <= idx + 1'b1;
      end
      done      <= done | (next == DONE);
      err       <= err | (next == ERR);
      // Lags done by one edge so the last write lands before the core runs.
      cpu_rst_n <= done;
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized frame stimulus checked against a queue-based image model.
module tb_imem_boot_loader;
  logic clk = 0, rst_n = 0, byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, imem_we, cpu_rst_n, done, err;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int ncyc = 0, last_we = -1, done_cyc = -1, rst_cyc = -1, done_rises = 0;
  logic done_q = 0, rst_q = 0;

  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      cap_addr.delete(); cap_data.delete();
      last_we = -1; done_cyc = -1; rst_cyc = -1; done_rises = 0;
    end else begin
      if (imem_we) begin
        cap_addr.push_back(imem_addr); cap_data.push_back(imem_wdata); last_we = ncyc;
      end
      if (done && !done_q) begin done_rises++; done_cyc = ncyc; end
      if (cpu_rst_n && !rst_q) rst_cyc = ncyc;
    end
    done_q = done;
    rst_q = cpu_rst_n;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(posedge clk);
    #1;
    byte_valid = 1; byte_data = b;
    while (!byte_ready && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (!byte_ready) begin
      errors++; $display("FAIL send_byte timeout: ready=%0b required=1", byte_ready);
    end else @(posedge clk);
    #1 byte_valid = 0;
  endtask

  task automatic send_frame(input int n, input int maxgap, input int nbytes);
    logic [7:0] bytes[$];
    bytes.push_back(8'(n >> 8)); bytes.push_back(8'(n));
    foreach (exp_q[i]) for (int k = 3; k >= 0; k--) bytes.push_back(8'(exp_q[i] >> (8 * k)));
    for (int i = 0; i < bytes.size() && i < nbytes; i++)
      send_byte(bytes[i], maxgap == 0 ? 0 : $urandom_range(0, maxgap));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_image(input string name);
    checks++;
    if (cap_addr.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s count: got %0d required %0d", name, cap_addr.size(), exp_q.size());
    end else
      foreach (exp_q[i]) begin
        checks++;
        if (cap_addr[i] !== 8'(i) || cap_data[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s word %0d: got [%0h]=%h required [%0h]=%h", name, i, cap_addr[i], cap_data[i], i, exp_q[i]);
        end
      end
    checks++;
    if (done !== 1 || cpu_rst_n !== 1 || err !== 0 || byte_ready !== 0) begin
      errors++;
      $display("FAIL %s final: done=%b rst_n=%b err=%b ready=%b required 1 1 0 0", name, done, cpu_rst_n, err, byte_ready);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1 rst_n = 0; #1;
    checks++;
    if ({byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, done, err} !== '0) begin
      errors++;
      $display("FAIL reset values: ready=%b we=%b addr=%h wdata=%h rst_n=%b done=%b err=%b required all 0",
               byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, done, err);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    checks++;
    if (byte_ready !== 0) begin errors++; $display("FAIL ready before edge: got %b required 0", byte_ready); end
    @(posedge clk); #1;
    checks++;
    if (byte_ready !== 1) begin errors++; $display("FAIL ready after edge: got %b required 1", byte_ready); end
  endtask

  task automatic test_basic();
    exp_q = '{32'h20080005, 32'hAC08003C};
    send_frame(2, 0, 1 << 20);
    check_image("basic");
    checks++;
    if (done_cyc !== last_we || rst_cyc !== last_we + 1) begin
      errors++;
      $display("FAIL basic timing: done@%0d rst@%0d required done@%0d rst@%0d", done_cyc, rst_cyc, last_we, last_we + 1);
    end
  endtask

  task automatic test_zero();
    exp_q = {};
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    checks++;
    if (done !== 1 || cpu_rst_n !== 0 || byte_ready !== 0) begin
      errors++; $display("FAIL zero after len: done=%b rst_n=%b ready=%b required 1 0 0", done, cpu_rst_n, byte_ready);
    end
    repeat (2) @(posedge clk); #1;
    check_image("zero");
  endtask

  task automatic test_err(input int n);
    exp_q = {};
    send_frame(n, 2, 2);
    repeat (5) @(posedge clk); #1;
    checks++;
    if (err !== 1 || byte_ready !== 0 || cpu_rst_n !== 0 || done !== 0 || cap_addr.size() !== 0) begin
      errors++;
      $display("FAIL err n=%0d: err=%b ready=%b rst_n=%b done=%b writes=%0d required 1 0 0 0 0",
               n, err, byte_ready, cpu_rst_n, done, cap_addr.size());
    end
  endtask

  task automatic test_gaps(input int nw, input string name);
    exp_q = {};
    if (nw == 0) exp_q = '{32'h20080005, 32'hAC08003C};
    else repeat (nw) exp_q.push_back($urandom);
    send_frame(exp_q.size(), 5, 1 << 20);
    check_image(name);
  endtask

  task automatic test_mid_reset();
    exp_q = '{32'h20080005, 32'hAC08003C};
    send_frame(2, 0, 6);
    test_reset();
    checks++;
    if (cap_addr.size() !== 0 || done !== 0) begin
      errors++; $display("FAIL mid reset: writes=%0d done=%b required 0 0", cap_addr.size(), done);
    end
    send_frame(2, 0, 1 << 20);
    check_image("reload");
  endtask

  task automatic test_full();
    logic [31:0] base = $urandom;
    exp_q = {};
    for (int i = 0; i < 256; i++) exp_q.push_back(base + 32'(i));
    send_frame(256, 0, 1 << 20);
    check_image("full");
    checks++;
    if (done_rises !== 1 || cap_addr.size() == 0 || cap_addr[cap_addr.size() - 1] !== 8'hFF) begin
      errors++;
      $display("FAIL full: done_rises=%0d last_addr=%h required 1 ff", done_rises,
               cap_addr.size() ? cap_addr[cap_addr.size() - 1] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset();
    test_zero();
    test_reset();
    test_err(16'h0101);
    test_reset();
    test_err($urandom_range(257, 65535));
    test_reset();
    test_gaps(0, "gaps");
    test_reset();
    test_gaps($urandom_range(1, 12), "random");
    test_reset();
    test_mid_reset();
    test_reset();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
